// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Port 0 (pipeline) has priority; a starvation counter guarantees port 1 progress.
module dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Latched transaction: winner id, direction, address, write data
  typedef struct packed {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] starve, starve_nxt;
  txn_t          txn, txn_nxt;
  logic          p0_rvalid_nxt, p1_rvalid_nxt;
  logic [DW-1:0] p0_rdata_nxt, p1_rdata_nxt;
  logic          pick1;

  // State, transaction and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      starve    <= '0;
      txn       <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      starve    <= starve_nxt;
      txn       <= txn_nxt;
      p0_rvalid <= p0_rvalid_nxt;
      p1_rvalid <= p1_rvalid_nxt;
      p0_rdata  <= p0_rdata_nxt;
      p1_rdata  <= p1_rdata_nxt;
    end
  end

  // Arbitration, next-state and response capture
  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve;
    txn_nxt       = txn;
    p0_gnt        = 1'b0;
    p1_gnt        = 1'b0;
    p0_rvalid_nxt = 1'b0;
    p1_rvalid_nxt = 1'b0;
    p0_rdata_nxt  = p0_rdata;
    p1_rdata_nxt  = p1_rdata;
    pick1         = 1'b0;
    case (state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          pick1  = p1_req && (!p0_req || (starve == LIM));
          p1_gnt = pick1;
          p0_gnt = !pick1;
          if (pick1) begin
            txn_nxt    = {1'b1, p1_we, p1_addr, p1_wdata};
            starve_nxt = '0;
          end else begin
            txn_nxt = {1'b0, p0_we, p0_addr, p0_wdata};
            // Contested loss; p0 only wins a contest below the limit, so this saturates
            if (p1_req && (starve != LIM)) starve_nxt = starve + CW'(1);
          end
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (txn.id) begin
          p1_rvalid_nxt = 1'b1;
          p1_rdata_nxt  = mem_rd;
        end else begin
          p0_rvalid_nxt = 1'b1;
          p0_rdata_nxt  = mem_rd;
        end
        state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory drive comes straight from the latched transaction
  assign mem_a  = txn.addr;
  assign mem_wd = txn.wdata;
  assign mem_we = (state == S_ACCESS) && txn.we;
  assign busy   = (state != S_IDLE);

endmodule
